// File: rtl/axis_fifo_sync.sv
// axis_fifo_sync: single-clock, first-word-fall-through AXI-Stream FIFO.
// Buffers converter output ahead of a consumer that may apply backpressure,
// and reports its fill level with almost-full/almost-empty flags.
//
// Pointers carry one extra wrap bit so that full and empty are distinguished
// without a separate count register; level is their modular difference.
// All status outputs come from registered state only, so there is no
// combinational path from m_axis_tready to s_axis_tready or from
// s_axis_tvalid to m_axis_tvalid.

module axis_fifo_sync #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int DEPTH          = 16,
  parameter int AFULL_LEVEL    = 12,
  parameter int AEMPTY_LEVEL   = 2
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      almost_full,
  output logic                      almost_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AFULL_TH  = PW'(AFULL_LEVEL);
  localparam logic [PW-1:0] AEMPTY_TH = PW'(AEMPTY_LEVEL);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic                      rst_hold;
  logic                      empty;
  logic                      full;
  logic                      wr_en;
  logic                      rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Input side stays closed until the first clock edge after reset release.
  assign s_axis_tready = ~full & ~rst_hold;
  assign m_axis_tvalid = ~empty;

  assign wr_en = s_axis_tvalid & s_axis_tready;
  assign rd_en = m_axis_tvalid & m_axis_tready;

  // Head word is read straight out of the array; zero when nothing is queued.
  assign m_axis_tdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  assign level        = wr_ptr - rd_ptr;
  assign almost_full  = (level >= AFULL_TH);
  assign almost_empty = (level <= AEMPTY_TH);

  // Hold the write side off for one edge after reset so no handshake can
  // race the reset release.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rst_hold <= 1'b1;
    end else begin
      rst_hold <= 1'b0;
    end
  end

  // Write pointer advances on every accepted input word.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Read pointer advances on every word taken by the consumer.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_ptr <= '0;
    end else if (rd_en) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array, deliberately not reset; a write can never land on the
  // head slot while the FIFO is non-empty, so the presented word is stable.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
    end
  end

endmodule

// File: tb/tb_axis_fifo_sync.sv
// Testbench for axis_fifo_sync: random and directed stimulus, a queue-based
// reference model, and a negedge monitor that compares every DUT output.

module tb_axis_fifo_sync;

  localparam int W      = 32;
  localparam int DEPTH  = 16;
  localparam int AFULL  = 12;
  localparam int AEMPTY = 2;

  logic            aclk;
  logic            areset;
  logic [W-1:0]    s_axis_tdata;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic [W-1:0]    m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [4:0]      level;
  logic            almost_full;
  logic            almost_empty;

  axis_fifo_sync #(
    .AXI_DATA_WIDTH(W),
    .DEPTH(DEPTH),
    .AFULL_LEVEL(AFULL),
    .AEMPTY_LEVEL(AEMPTY)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .level(level),
    .almost_full(almost_full),
    .almost_empty(almost_empty)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  int           rd_cnt = 0;
  int           wr_cnt = 0;
  bit           hold_m = 1'b1;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_data;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference for the post-reset quiet edge: writes open one edge after release.
  always @(posedge aclk or posedge areset) begin
    if (areset) hold_m = 1'b1;
    else        hold_m = 1'b0;
  end

  // Reset throws away everything the model holds, including a pending push.
  always @(posedge areset) begin
    exp_q.delete();
    prev_stall = 1'b0;
  end

  // Monitor: compare outputs against the model, then account for the
  // handshakes that will complete on the coming rising edge.
  always @(negedge aclk) begin
    int sz;
    if (areset) begin
      chk("rst_s_tready", s_axis_tready, 0);
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_m_tdata", m_axis_tdata, 0);
      chk("rst_level", level, 0);
      chk("rst_afull", almost_full, 0);
      chk("rst_aempty", almost_empty, 1);
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      sz = exp_q.size();
      chk("level", level, sz);
      chk("m_tvalid", m_axis_tvalid, sz != 0);
      chk("s_tready", s_axis_tready, !hold_m && sz < DEPTH);
      chk("almost_full", almost_full, sz >= AFULL);
      chk("almost_empty", almost_empty, sz <= AEMPTY);
      if (sz != 0) chk("m_tdata", m_axis_tdata, exp_q[0]);
      else         chk("m_tdata_empty", m_axis_tdata, 0);
      if (prev_stall && m_axis_tvalid) chk("stall_hold", m_axis_tdata, prev_data);
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        rd_cnt++;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        exp_q.push_back(s_axis_tdata);
        wr_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Present one word and keep it valid until accepted (bounded).
  task automatic send(input logic [W-1:0] d);
    bit acc;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge aclk);
      acc = s_axis_tready;
      step();
    end
    if (!acc) chk("send_timeout", 0, 1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 100 && m_axis_tvalid; i++) step();
    chk("drain_empty", m_axis_tvalid, 0);
    m_axis_tready = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    repeat (2) step();
    #2 areset = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    areset        = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    #3;
    chk("init_level", level, 0);
    chk("init_aempty", almost_empty, 1);
    do_reset();
    chk("post_rst_ready", s_axis_tready, 1);

    // Fill and drain.
    for (int i = 1; i <= DEPTH; i++) send(W'(i));
    chk("fill_level", level, DEPTH);
    chk("fill_ready", s_axis_tready, 0);
    chk("fill_afull", almost_full, 1);
    s_axis_tdata  = 32'h0000_0011;
    s_axis_tvalid = 1'b1;
    repeat (3) step();
    chk("full_no_write", level, DEPTH);
    s_axis_tvalid = 1'b0;
    drain();
    chk("drain_level", level, 0);
    chk("drain_aempty", almost_empty, 1);

    // Full-rate streaming.
    base = rd_cnt;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_axis_tdata = 32'h1000_0000 + W'(i);
      @(negedge aclk);
      chk("stream_ready", s_axis_tready, 1);
      if (i > 0) chk("stream_level", level, 1);
      step();
    end
    s_axis_tvalid = 1'b0;
    step();
    chk("stream_count", rd_cnt - base, 100);
    chk("stream_empty", m_axis_tvalid, 0);
    m_axis_tready = 1'b0;

    // Backpressure stability.
    for (int i = 1; i <= 3; i++) send(32'hA5A5_0000 + W'(i));
    base = rd_cnt;
    for (int i = 0; i < 200 && m_axis_tvalid; i++) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      step();
    end
    m_axis_tready = 1'b0;
    chk("bp_count", rd_cnt - base, 3);

    // Wrap-around with random valid/ready.
    base = rd_cnt;
    fork
      begin
        int sent = 0;
        bit acc;
        for (int c = 0; c < 5000 && sent < 200; c++) begin
          if (!s_axis_tvalid) begin
            s_axis_tvalid = 1'($urandom_range(0, 1));
            s_axis_tdata  = $urandom;
          end
          @(negedge aclk);
          acc = s_axis_tvalid && s_axis_tready;
          if (acc) sent++;
          step();
          if (acc) s_axis_tvalid = 1'b0;
        end
        s_axis_tvalid = 1'b0;
        chk("wrap_sent", sent, 200);
      end
      begin
        for (int c = 0; c < 6000 && (rd_cnt - base) < 200; c++) begin
          m_axis_tready = 1'($urandom_range(0, 1));
          step();
        end
        m_axis_tready = 1'b0;
      end
    join
    chk("wrap_read", rd_cnt - base, 200);
    chk("wrap_empty", m_axis_tvalid, 0);

    // Simultaneous read/write at full.
    for (int i = 0; i < DEPTH; i++) send(32'hB000_0000 + W'(i));
    chk("bfull_level", level, DEPTH);
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hBAD0_0000;
    step();
    chk("bfull_level_after", level, DEPTH - 1);
    chk("bfull_ready_after", s_axis_tready, 1);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    drain();

    // Write into empty with consumer ready.
    m_axis_tready = 1'b1;
    s_axis_tdata  = 32'hC0DE_0001;
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    chk("empty_tvalid_before", m_axis_tvalid, 0);
    step();
    s_axis_tvalid = 1'b0;
    chk("empty_tvalid_after", m_axis_tvalid, 1);
    chk("empty_level_after", level, 1);
    chk("empty_tdata_after", m_axis_tdata, 32'hC0DE_0001);
    step();
    m_axis_tready = 1'b0;

    // Reset mid-operation with 9 words queued.
    for (int i = 0; i < 9; i++) send(32'hD000_0000 + W'(i));
    chk("pre_rst_level", level, 9);
    s_axis_tdata  = 32'h1234_5678;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    #2 areset = 1'b1;
    #1;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_tdata", m_axis_tdata, 0);
    chk("mid_rst_ready", s_axis_tready, 0);
    chk("mid_rst_afull", almost_full, 0);
    chk("mid_rst_aempty", almost_empty, 1);
    m_axis_tready = 1'b0;
    #4 areset = 1'b0;
    s_axis_tdata = 32'hDEAD_BEEF;
    #1;
    chk("rel_ready_before_edge", s_axis_tready, 0);
    @(posedge aclk);
    #1;
    chk("rel_ready_after_edge", s_axis_tready, 1);
    chk("rel_level", level, 0);
    step();
    s_axis_tvalid = 1'b0;
    chk("rst_first_valid", m_axis_tvalid, 1);
    chk("rst_first_word", m_axis_tdata, 32'hDEAD_BEEF);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
